uart_tx_fifo: RTL
=================

# uart_tx_fifo

Buffered UART transmitter, the transmit-side counterpart of the team's UART receiver, using the same baud/clock parameterisation and the same 8N1 framing. It accepts bytes over a valid/ready handshake into a small internal FIFO and serialises them on `tx_o` LSB-first: start bit, DataWidth data bits, one stop bit. Queued bytes go out back-to-back with no idle gap, so a producer can push a multi-byte message in consecutive cycles.

## Interface
- BAUD, 9600, line bit rate.
- CLK_FREQ, 100_000_000, clk frequency in Hz.
- DataWidth, 8, data bits per frame.
- FIFO_DEPTH, 4, byte slots in the FIFO; power of two, at least 2.
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  DataWidth  byte to enqueue.
- data_valid  in  1  producer offers data_in this cycle.
- data_ready  out  1  FIFO can accept; a push occurs on an edge where data_valid && data_ready.
- tx_o  out  1  serial line; idles high.
- tx_busy  out  1  high while a frame is in progress or the FIFO is non-empty.
- tx_done  out  1  one-cycle pulse when a stop bit completes.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being sent.

## Operation
- L = CLK_FREQ / BAUD, integer division. Every bit, including start and stop, lasts exactly L clk cycles.
- The bit timer counts 0..L-1; the bit counter counts 0..DataWidth-1.
- FIFO: circular buffer with rd/wr pointers that wrap modulo FIFO_DEPTH, plus a count register.
  - data_ready = !rst && (fifo_count < FIFO_DEPTH), decoded from registered state.
  - When full, data_ready is low and data_in is ignored.
  - Push and pop on the same edge: count unchanged, both pointers advance.
- Shift register holds the byte being sent. tx_o is a registered output.
- S_IDLE: tx_o=1.
  - If fifo_count>0: pop the head into the shift register, drive tx_o<=0, clear the bit timer, go to S_START.
- S_START: when the timer reaches L-1, drive tx_o<=shift[0], clear the timer, go to S_DATA.
- S_DATA: when the timer reaches L-1:
  - If bitcounter = DataWidth-1: drive tx_o<=1, clear bitcounter, go to S_STOP.
  - Otherwise: shift right, drive tx_o<=next bit, increment bitcounter.
- S_STOP: when the timer reaches L-1, assert tx_done for one cycle, then:
  - If fifo_count>0: pop, drive tx_o<=0, go to S_START. There is no idle cycle between frames.
  - Otherwise: go to S_IDLE.
- tx_busy = (state != S_IDLE) || (fifo_count != 0).
- Reset, including mid-frame:
  - State goes to S_IDLE, tx_o=1, tx_done=0, fifo_count=0, pointers=0, timers=0.
  - The FIFO is flushed and the partial frame is abandoned; no tx_done is issued for it.

## Timing
- Reset values: tx_o=1, tx_done=0, tx_busy=0, fifo_count=0. data_ready=0 while rst is high and 1 on the first cycle after release.
- Latency: byte pushed on edge k into an empty FIFO while in S_IDLE. fifo_count=1 after edge k; the pop happens on edge k+1; tx_o falls after edge k+1.
- Frame length: exactly (DataWidth+2)*L cycles from the tx_o fall to the end of the stop bit.
- tx_done is high for the single cycle after the last stop-bit edge.
- Back-to-back frames: the next start bit begins on the same edge at which tx_done rises.
- A push on the same edge as an S_IDLE or S_STOP pop is accepted. The popped byte is the old head, never the byte being pushed.

## Test plan
Use CLK_FREQ=1_000_000, BAUD=100_000 (L=10) and DataWidth=8 (frame = 100 cycles).
- Single byte: push 0xA5 from idle -> tx_o low 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles. tx_done pulses once at cycle 100 after the fall; tx_busy is high from the push until tx_done.
- Burst: hold data_valid with 0x01..0x06 on consecutive accepts -> first byte popped immediately, next four fill the FIFO to fifo_count=4, data_ready drops, 0x06 waits and is accepted once a slot frees. Six frames go out contiguous (600 cycles, no high gap beyond stop bits), in order 0x01..0x06.
- Pointer wrap: push 10 bytes 0x10..0x19 paced one per frame -> decoded line output matches exactly and fifo_count never exceeds 1.
- Simultaneous push/pop: with fifo_count=2, push on the edge where S_STOP pops -> fifo_count stays 2 and byte order is preserved.
- Reset mid-frame: assert rst for 1 cycle during data bit 3 with 2 bytes queued -> tx_o=1 next cycle, fifo_count=0, no tx_done. Line stays high for 200 cycles; a new push of 0x3C then produces a clean frame.
- Idle: no data_valid for 1000 cycles after reset -> tx_o constantly 1, tx_busy=0, data_ready=1.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Producer-side byte handshake for the buffered UART transmitter.
// A byte moves on any clock edge where data_valid && data_ready.
interface uart_tx_fifo_if #(
  parameter int unsigned DataWidth = 8
);
  logic [DataWidth-1:0] data_in;
  logic                 data_valid;
  logic                 data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO feeding an LSB-first serialiser.
// Queued bytes go out back-to-back; the next start bit begins on the edge that raises tx_done.
module uart_tx_fifo #(
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CntW      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_fifo_if.slave   bus,
  output logic            tx_o,
  output logic            tx_busy,
  output logic            tx_done,
  output logic [CntW-1:0] fifo_count
);

  localparam int unsigned L      = CLK_FREQ / BAUD;
  localparam int unsigned TimerW = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned BitW   = (DataWidth > 1) ? $clog2(DataWidth) : 1;

  localparam logic [TimerW-1:0] TimerMax = TimerW'(L - 1);
  localparam logic [BitW-1:0]   BitMax   = BitW'(DataWidth - 1);
  localparam logic [CntW-1:0]   CntFull  = CntW'(FIFO_DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [DataWidth-1:0] mem_q [FIFO_DEPTH];

  logic push, pop;

  assign bus.data_ready = !rst && (count_q != CntFull);
  assign push           = bus.data_valid && bus.data_ready;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          timer_d = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (timer_q == TimerMax) begin
          tx_d    = shift_q[0];
          timer_d = '0;
          state_d = StData;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StData: begin
        if (timer_q == TimerMax) begin
          timer_d = '0;
          if (bit_q == BitMax) begin
            tx_d    = 1'b1;
            bit_d   = '0;
            state_d = StStop;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StStop: begin
        if (timer_q == TimerMax) begin
          done_d  = 1'b1;
          timer_d = '0;
          // Chain straight into the next start bit so queued frames have no idle gap.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_in;
  end

  assign tx_o       = tx_q;
  assign tx_done    = done_q;
  assign fifo_count = count_q;
  assign tx_busy    = (state_q != StIdle) || (count_q != '0);

endmodule
